// File: rtl/wdf_lattice_dec2_pkg.sv
// rtl/wdf_lattice_dec2_pkg.sv - shared constants, FSM states and saturation helper
package wdf_pkg;

  localparam int ALPHA_W    = 11;
  localparam int ALPHA_FRAC = 10;
  localparam int ROUND      = 1 << (ALPHA_FRAC - 1);
  localparam int SAT_W      = 48;

  typedef enum logic [1:0] {IDLE, HALF, RUN, OUT} state_t;

  // clamp a wide signed value into the signed range of w bits
  function automatic logic signed [SAT_W-1:0] sat(input logic signed [SAT_W-1:0] v, input int w);
    logic signed [SAT_W-1:0] lo;
    logic signed [SAT_W-1:0] hi;
    lo = '1;
    lo = lo << (w - 1);
    hi = ~lo;
    if (v > hi)
      return hi;
    else if (v < lo)
      return lo;
    else
      return v;
  endfunction

endpackage

// File: rtl/wdf_lattice_dec2_if.sv
// rtl/wdf_lattice_dec2_if.sv - sample input/output handshake bundle
interface wdf_lattice_dec2_if #(
  parameter int DW = 12
);
  logic [DW-1:0] din;
  logic          din_vld;
  logic          din_rdy;
  logic [DW-1:0] dout;
  logic          dout_vld;

  modport master (output din, output din_vld, input din_rdy, input dout, input dout_vld);
  modport slave  (input din, input din_vld, output din_rdy, output dout, output dout_vld);
endinterface

// File: rtl/wdf_adaptor_sat.sv
// rtl/wdf_adaptor_sat.sv - combinational saturating two-port wave-digital adaptor
module wdf_adaptor_sat
  import wdf_pkg::*;
#(
  parameter int IW = 14
) (
  input  logic signed [IW-1:0]      a1,
  input  logic signed [IW-1:0]      a2,
  input  logic signed [ALPHA_W-1:0] alpha,
  output logic signed [IW-1:0]      b1,
  output logic signed [IW-1:0]      b2
);
  // product width covers alpha*d plus the rounding add without overflow
  localparam int PW = IW + 1 + ALPHA_W;

  logic signed [IW:0]   d;
  logic signed [PW-1:0] p;
  logic signed [PW-1:0] g;

  // rounded scaled difference, then saturating reflected outputs
  always_comb begin
    d  = (IW+1)'(a2) - (IW+1)'(a1);
    p  = PW'(alpha) * PW'(d);
    g  = (p + PW'(ROUND)) >>> ALPHA_FRAC;
    b1 = IW'(sat(SAT_W'(a2) + SAT_W'(g), IW));
    b2 = IW'(sat(SAT_W'(a1) + SAT_W'(g), IW));
  end

endmodule

// File: rtl/wdf_lattice_dec2.sv
// rtl/wdf_lattice_dec2.sv - half-band lattice WDF decimator-by-2 with one shared adaptor
module wdf_lattice_dec2
  import wdf_pkg::*;
#(
  parameter int DW   = 12,
  parameter int NSEC = 2,
  parameter int IW   = DW + 2
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [2*NSEC*ALPHA_W-1:0]     alpha,
  wdf_lattice_dec2_if.slave             bus
);
  localparam int NS2 = 2 * NSEC;
  localparam int CW  = (NS2 > 1) ? $clog2(NS2) : 1;

  state_t                   state;
  logic [CW-1:0]            cnt;
  logic signed [DW-1:0]     xe;
  logic signed [DW-1:0]     xo;
  logic signed [IW-1:0]     s [NS2];
  logic signed [IW-1:0]     pipe;
  logic signed [IW-1:0]     y0;
  logic signed [IW-1:0]     y1;

  logic signed [IW-1:0]      a1;
  logic signed [IW-1:0]      a2;
  logic signed [IW-1:0]      b1;
  logic signed [IW-1:0]      b2;
  logic signed [ALPHA_W-1:0] alpha_k;
  logic signed [IW:0]        sum;
  logic signed [IW:0]        half;
  logic [DW-1:0]             dout_next;

  // input can only be taken while collecting a pair
  assign bus.din_rdy = (state == IDLE) || (state == HALF);

  // select operands of the section addressed by cnt
  always_comb begin
    a2      = '0;
    alpha_k = '0;
    for (int k = 0; k < NS2; k++) begin
      if (cnt == CW'(k)) begin
        a2      = s[k];
        alpha_k = alpha[k*ALPHA_W +: ALPHA_W];
      end
    end
    if (cnt == '0)
      a1 = IW'(xe);
    else if (cnt == CW'(NSEC))
      a1 = IW'(xo);
    else
      a1 = pipe;
  end

  wdf_adaptor_sat #(.IW(IW)) u_adaptor (
    .a1    (a1),
    .a2    (a2),
    .alpha (alpha_k),
    .b1    (b1),
    .b2    (b2)
  );

  // rounded half-sum of branch outputs; branch 1 output is b1 of the last section
  always_comb begin
    sum       = (IW+1)'(y0) + (IW+1)'(b1) + (IW+1)'(1);
    half      = sum >>> 1;
    dout_next = DW'(sat(SAT_W'(half), DW));
  end

  // pair capture, serial section evaluation and output registration
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      cnt          <= '0;
      xe           <= '0;
      xo           <= '0;
      pipe         <= '0;
      y0           <= '0;
      y1           <= '0;
      bus.dout     <= '0;
      bus.dout_vld <= 1'b0;
      for (int k = 0; k < NS2; k++) s[k] <= '0;
    end else begin
      bus.dout_vld <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.din_vld) begin
            xe    <= bus.din;
            state <= HALF;
          end
        end
        HALF: begin
          if (bus.din_vld) begin
            xo    <= bus.din;
            cnt   <= '0;
            state <= RUN;
          end
        end
        RUN: begin
          for (int k = 0; k < NS2; k++) begin
            if (cnt == CW'(k)) s[k] <= b2;
          end
          pipe <= b1;
          if (cnt == CW'(NSEC - 1)) y0 <= b1;
          if (cnt == CW'(NS2 - 1)) begin
            y1           <= b1;
            bus.dout     <= dout_next;
            bus.dout_vld <= 1'b1;
            cnt          <= '0;
            state        <= OUT;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        OUT: begin
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
